// File: rtl/cpu_program_loader.sv
// Streams a host-written 16x8 program image into a CPU as address/data pairs over a ready handshake.
// Optional watchdog enabled by defining LOADER_TIMEOUT_EN.
module cpu_program_loader #(
  parameter int RAM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       cpu_ready,
  input  logic       cpu_done,
  output logic       programming,
  output logic [7:0] prog_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    XFER_ADDR = 3'd2,
    XFER_DATA = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(RAM_BYTES - 1);

  if (RAM_BYTES < 1 || RAM_BYTES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("cpu_program_loader: RAM_BYTES must be 1..16 and TIMEOUT_CYCLES 1..255");
  end

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] image_rd [16];
  logic       image_we;
  logic       wdog_expire;

  // Host writes are locked out for the whole load so the CPU sees a stable image.
  assign image_we = wr_en && !busy;

  for (genvar gi = 0; gi < 16; gi++) begin : g_image
    logic [7:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (image_we && wr_addr == 4'(gi)) begin
        entry_d = wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign image_rd[gi] = entry_q;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wdog_q, wdog_d;
  logic       wdog_active;

  assign wdog_active = (state_q == XFER_ADDR) || (state_q == XFER_DATA) || (state_q == WAIT_DONE);
  assign wdog_expire = wdog_active && (wdog_q + 8'd1 == WDOG_LIMIT);

  // Any state change restarts the count, so the limit applies per handshake step.
  always_comb begin
    wdog_d = '0;
    if (wdog_active && state_d == state_q) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = ARM;
          idx_d   = '0;
        end
      end
      ARM: begin
        state_d = XFER_ADDR;
      end
      XFER_ADDR: begin
        // Early done beats a simultaneous ready.
        if (cpu_done || wdog_expire) begin
          state_d = ERR;
        end else if (cpu_ready) begin
          state_d = XFER_DATA;
        end
      end
      XFER_DATA: begin
        if (cpu_done || wdog_expire) begin
          state_d = ERR;
        end else if (cpu_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = WAIT_DONE;
          end else begin
            state_d = XFER_ADDR;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      WAIT_DONE: begin
        if (cpu_done) begin
          state_d = DONE;
        end else if (wdog_expire) begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    programming = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    prog_data   = '0;
    case (state_q)
      ARM: begin
        programming = 1'b1;
        busy        = 1'b1;
      end
      XFER_ADDR: begin
        programming = 1'b1;
        busy        = 1'b1;
        prog_data   = {4'h0, idx_q};
      end
      XFER_DATA: begin
        programming = 1'b1;
        busy        = 1'b1;
        prog_data   = image_rd[idx_q];
      end
      WAIT_DONE: begin
        programming = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: a 16-byte and a 4-byte loader share stimulus; a monitor checks every CPU handshake.
module tb_cpu_program_loader;
  localparam int N_A = 16;
  localparam int N_B = 4;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       cpu_ready = 1'b0;
  logic       cpu_done = 1'b0;

  logic       prog_a, busy_a, done_a, err_a;
  logic [7:0] pd_a;
  logic       prog_b, busy_b, done_b, err_b;
  logic [7:0] pd_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [16];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic       prev_a = 1'b0;
  logic       prev_b = 1'b0;

  always #5 clk = ~clk;

  cpu_program_loader #(.RAM_BYTES(N_A), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .programming(prog_a), .prog_data(pd_a), .busy(busy_a), .done(done_a), .error(err_a)
  );

  cpu_program_loader #(.RAM_BYTES(N_B), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .programming(prog_b), .prog_data(pd_b), .busy(busy_b), .done(done_b), .error(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Per-cycle view of one loader: ARM shows 00, every ready edge consumes the next queued byte, WAIT_DONE shows 00.
  task automatic mon_dut(input string tag, input logic prog, input logic [7:0] pd, input logic bsy,
                         input logic prev, input bit is_b);
    logic [7:0] exp;
    bit         have;
    have = is_b ? (q_b.size() > 0) : (q_a.size() > 0);
    chk({tag, "_busy_eq_prog"}, 32'(bsy), 32'(prog), 1'b0);
    if (!prog) begin
      chk({tag, "_pd_idle"}, 32'(pd), 32'h0, 1'b0);
    end else if (!prev) begin
      chk({tag, "_pd_arm"}, 32'(pd), 32'h0, 1'b1);
    end else if (cpu_ready && !cpu_done && have) begin
      exp = is_b ? q_b.pop_front() : q_a.pop_front();
      chk({tag, "_xfer"}, 32'(pd), 32'(exp), 1'b1);
    end else if (!have) begin
      chk({tag, "_pd_wait"}, 32'(pd), 32'h0, 1'b0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_dut("a", prog_a, pd_a, busy_a, prev_a, 1'b0);
      mon_dut("b", prog_b, pd_b, busy_b, prev_b, 1'b1);
      prev_a = prog_a;
      prev_b = prog_b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_img(input logic [3:0] a, input logic [7:0] d, input bit accepted);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (accepted) img[a] = d;
  endtask

  // Expected stream: address then data for each location, in index order.
  task automatic begin_load();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < N_A; i++) begin
      q_a.push_back(8'(i));
      q_a.push_back(img[i]);
    end
    for (int i = 0; i < N_B; i++) begin
      q_b.push_back(8'(i));
      q_b.push_back(img[i]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_xfers(input int mode, output int n, output int nb);
    n  = 0;
    nb = 0;
    while (q_a.size() > 0 && n < 2000) begin
      case (mode)
        0:       cpu_ready = (n % 3 == 2);
        1:       cpu_ready = 1'b1;
        default: cpu_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
      nb += int'(busy_a);
    end
    cpu_ready = 1'b0;
    chk("xfers_complete_a", q_a.size(), 0, 1'b1);
    chk("xfers_complete_b", q_b.size(), 0, 1'b1);
  endtask

  task automatic finish_load(input int w, output int nb);
    nb = 0;
    repeat (w) begin
      tick();
      nb += int'(busy_a);
    end
    chk("wait_done_busy_a", 32'(busy_a), 32'h1, 1'b1);
    chk("wait_done_busy_b", 32'(busy_b), 32'h1, 1'b1);
    chk("wait_done_flag_a", 32'(done_a), 32'h0, 1'b1);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    nb += int'(busy_a);
    chk("done_a", {done_a, prog_a, busy_a, err_a}, 32'b1000, 1'b1);
    chk("done_b", {done_b, prog_b, busy_b, err_b}, 32'b1000, 1'b1);
  endtask

  initial begin
    int n, nb, nw, bc, w;
    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    repeat (3) tick();
    chk("reset_out_a", {prog_a, busy_a, done_a, err_a, pd_a}, 32'h0, 1'b1);
    chk("reset_out_b", {prog_b, busy_b, done_b, err_b, pd_b}, 32'h0, 1'b1);
    rst_n = 1'b1;
    tick();

    // Reference image A0+i, CPU ready every third cycle.
    for (int i = 0; i < 16; i++) write_img(4'(i), 8'hA0 + 8'(i), 1'b1);
    begin_load();
    run_xfers(0, n, nb);
    finish_load(2, nw);

    // Ready held high: one transfer per cycle after the single ARM cycle.
    cpu_ready = 1'b1;
    begin_load();
    bc = int'(busy_a);
    run_xfers(1, n, nb);
    w = int'($urandom_range(1, 5));
    finish_load(w, nw);
    chk("burst_cycles", n, 1 + 2 * N_A, 1'b1);
    chk("burst_busy_cycles", bc + nb + nw, 1 + 2 * N_A + (w + 1), 1'b1);

    // Random image; a write while busy must be dropped.
    for (int i = 0; i < 16; i++) write_img(4'(i), 8'($urandom_range(0, 255)), 1'b1);
    write_img(4'd2, 8'h5A, 1'b1);
    begin_load();
    write_img(4'd2, 8'hFF, 1'b0);
    run_xfers(2, n, nb);
    finish_load(int'($urandom_range(0, 3)), nw);
    begin_load();
    run_xfers(0, n, nb);
    finish_load(1, nw);

    // Early done together with ready at XFER_ADDR idx 3.
    cpu_ready = 1'b1;
    begin_load();
    repeat (7) tick();
    chk("pre_early_pd_a", 32'(pd_a), 32'h3, 1'b1);
    cpu_done = 1'b1;
    tick();
    cpu_done  = 1'b0;
    cpu_ready = 1'b0;
    chk("early_done_a", {err_a, prog_a, busy_a, done_a, pd_a}, 32'h800, 1'b1);
    chk("early_done_b", {err_b, prog_b, busy_b, done_b, pd_b}, 32'h800, 1'b1);
    begin_load();
    run_xfers(2, n, nb);
    finish_load(1, nw);

    // Reset in XFER_DATA at idx 5 clears the image.
    cpu_ready = 1'b1;
    begin_load();
    repeat (12) tick();
    chk("pre_rst_pd_a", 32'(pd_a), 32'(img[5]), 1'b1);
    rst_n = 1'b0;
    cpu_ready = 1'b0;
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    tick();
    chk("mid_rst_a", {prog_a, busy_a, pd_a}, 32'h0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    begin_load();
    run_xfers(2, n, nb);
    finish_load(0, nw);

    // CPU never ready.
    cpu_ready = 1'b0;
    begin_load();
    tick();
`ifdef LOADER_TIMEOUT_EN
    repeat (TMO - 1) tick();
    chk("tmo_not_yet_a", 32'(err_a), 32'h0, 1'b1);
    tick();
    chk("tmo_err_a", {err_a, prog_a, busy_a}, 32'b100, 1'b1);
    chk("tmo_err_b", {err_b, prog_b, busy_b}, 32'b100, 1'b1);
`else
    repeat (TMO + 20) tick();
    chk("no_tmo_a", {err_a, prog_a, busy_a, pd_a}, 32'h300, 1'b1);
    chk("no_tmo_b", {err_b, prog_b, busy_b, pd_b}, 32'h300, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
CPU_PROGRAM_LOADER -- requirements
Module: cpu_program_loader

Interface
REQ-001 Parameter RAM_BYTES, default 16, number of CPU RAM locations streamed per load; legal range 1..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, idle-cycle limit per handshake step; used only when the watchdog is compiled in.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  host image write strobe.
REQ-007 wr_addr  in  4  host image write address.
REQ-008 wr_data  in  8  host image write data.
REQ-009 start  in  1  begin load; sampled at a clock edge.
REQ-010 cpu_ready  in  1  from CPU ready_for_ui; CPU consumes prog_data at every edge where it is 1.
REQ-011 cpu_done  in  1  from CPU done_load.
REQ-012 programming  out  1  to CPU programming input.
REQ-013 prog_data  out  8  to CPU ui_in.
REQ-014 busy  out  1  high in ARM, XFER_ADDR, XFER_DATA and WAIT_DONE.
REQ-015 done  out  1  high in DONE.
REQ-016 error  out  1  high in ERR.

Function
REQ-017 Image store: 16x8 registers; written when wr_en=1 and busy=0; writes while busy=1 are ignored.
REQ-018 States: IDLE, ARM, XFER_ADDR, XFER_DATA, WAIT_DONE, DONE, ERR; a 4-bit index idx selects the current location.
REQ-019 IDLE, DONE or ERR with start=1 -> ARM, idx=0; start is ignored in all other states.
REQ-020 ARM: programming=1 for exactly one cycle, prog_data=0; then -> XFER_ADDR.
REQ-021 XFER_ADDR: prog_data={4'h0,idx}; an edge with cpu_ready=1 -> XFER_DATA.
REQ-022 XFER_DATA: prog_data=image[idx] combinationally from the registered idx; an edge with cpu_ready=1 -> XFER_ADDR with idx+1, or -> WAIT_DONE if idx==RAM_BYTES-1; idx never wraps.
REQ-023 cpu_ready held high on consecutive cycles SHALL advance one transfer per cycle with no bubble.
REQ-024 programming=1 in ARM, XFER_ADDR, XFER_DATA and WAIT_DONE; 0 elsewhere.
REQ-025 WAIT_DONE: prog_data=0; an edge with cpu_done=1 -> DONE, with programming low from the next cycle.
REQ-026 cpu_done=1 in XFER_ADDR or XFER_DATA (early done) -> ERR; early done takes priority over a simultaneous cpu_ready.
REQ-027 prog_data=0 in IDLE, DONE and ERR.
REQ-028 Total handshake count per load: 2*RAM_BYTES transfers with cpu_ready high.

Reset
REQ-029 With rst_n=0 at any time, including mid-load, the state SHALL be IDLE, idx=0, the image cleared to 0 and the watchdog count 0.
REQ-030 Outputs during reset: programming=0, prog_data=0, busy=0, done=0, error=0.

Configuration
REQ-031 Macro LOADER_TIMEOUT_EN defined: an 8-bit watchdog clears on every state transition and increments each cycle in XFER_ADDR, XFER_DATA and WAIT_DONE; reaching TIMEOUT_CYCLES -> ERR.
REQ-032 Macro LOADER_TIMEOUT_EN undefined: no watchdog logic; the block waits indefinitely and only early done causes ERR.

Verification
REQ-033 Write image[i]=8'hA0+i for i=0..15, start, CPU model with cpu_ready pulsed every 3 cycles -> prog_data sequence 00,A0,01,A1,...,0F,AF; WAIT_DONE; cpu_done pulse -> done=1, programming=0.
REQ-034 cpu_ready held constantly 1 -> 32 transfers complete in 32 consecutive cycles after ARM; busy high for 1+32+wait cycles.
REQ-035 Assert rst_n=0 in XFER_DATA with idx=5 -> next cycle programming=0, busy=0, image reads back 0 on a subsequent load.
REQ-036 cpu_done=1 together with cpu_ready=1 in XFER_ADDR at idx=3 -> ERR, error=1, programming=0; start -> ARM and a clean reload.
REQ-037 LOADER_TIMEOUT_EN defined, cpu_ready held 0 -> error=1 exactly TIMEOUT_CYCLES cycles after XFER_ADDR entry; undefined -> remains in XFER_ADDR with busy=1.
REQ-038 wr_en=1, wr_addr=2, wr_data=8'hFF while busy=1 -> image[2] unchanged on the next load; RAM_BYTES=4 -> WAIT_DONE after the transfer of idx 3.
